// File: rtl/regfile_pkg.sv
// Shared constants and configuration helpers for the multi-port register file.
package regfile_pkg;

   localparam int RF_WIDTH = 32;
   localparam int RF_DEPTH = 32;
   localparam int RF_NRD   = 2;

   function automatic int bytes_of(input int width);
      return width / 8;
   endfunction

   function automatic bit cfg_ok(input int width, input int depth, input int nrd);
      return (width % 8 == 0) && (depth >= 2) && (nrd >= 1) && (nrd <= 4);
   endfunction

endpackage

// File: rtl/regfile_word.sv
// One storage word with synchronous active-low clear and byte-enabled write.
module regfile_word
   import regfile_pkg::*;
#(
   parameter  int WIDTH = RF_WIDTH,
   localparam int NB    = bytes_of(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [NB-1:0]    wbe_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_d;

   always_comb begin
      word_d = word_q;
      if (we_i) begin
         for (int k = 0; k < NB; k++) begin
            if (wbe_i[k]) word_d[8*k +: 8] = wdata_i[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) word_q <= '0;
      else        word_q <= word_d;
   end

   assign q_o = word_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, one byte-enabled
// synchronous write port, optional hardwired-zero entry 0 and write bypass.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = RF_WIDTH,
   parameter  int DEPTH    = RF_DEPTH,
   parameter  int NRD      = RF_NRD,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = $clog2(DEPTH),
   localparam int NB       = bytes_of(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [NB-1:0]        wbe,
   input  logic [NRD*AW-1:0]    raddr,
   output logic [NRD*WIDTH-1:0] rdata
);

   if (!cfg_ok(WIDTH, DEPTH, NRD)) begin : g_bad_cfg
      $error("regfile_mp: unsupported WIDTH/DEPTH/NRD combination");
   end

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] word_val [DEPTH];
   logic             waddr_ok;
   logic             wvalid;
   logic [WIDTH-1:0] wr_old;
   logic [WIDTH-1:0] wr_merged;
   logic [WIDTH-1:0] rd_port [NRD];

   // A write to the hardwired-zero entry is treated as no write at all, so it
   // can neither store nor bypass.
   assign waddr_ok = ({1'b0, waddr} < DEPTH_W) && !((ZERO_REG != 0) && (waddr == '0));
   assign wvalid   = rst_n && we && waddr_ok;

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
         assign word_val[i] = '0;
      end else begin : g_store
         regfile_word #(.WIDTH(WIDTH)) u_word (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (wvalid && (waddr == AW'(i))),
            .wbe_i   (wbe),
            .wdata_i (wdata),
            .q_o     (word_val[i])
         );
      end
   end

   assign wr_old = waddr_ok ? word_val[waddr] : '0;

   always_comb begin
      wr_merged = wr_old;
      for (int k = 0; k < NB; k++) begin
         if (wbe[k]) wr_merged[8*k +: 8] = wdata[8*k +: 8];
      end
   end

   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         rd_port[p] = '0;
         if (rst_n && ({1'b0, raddr[p*AW +: AW]} < DEPTH_W)
             && !((ZERO_REG != 0) && (raddr[p*AW +: AW] == '0))) begin
            if ((BYPASS != 0) && wvalid && (raddr[p*AW +: AW] == waddr))
               rd_port[p] = wr_merged;
            else
               rd_port[p] = word_val[raddr[p*AW +: AW]];
         end
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      assign rdata[p*WIDTH +: WIDTH] = rd_port[p];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance A uses defaults (zero reg, bypass, 2 ports);
// instance B uses DEPTH=24, NRD=4, no zero reg, no bypass.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst_n;

   logic         we_a;
   logic [4:0]   waddr_a;
   logic [31:0]  wdata_a;
   logic [3:0]   wbe_a;
   logic [9:0]   raddr_a;
   logic [63:0]  rdata_a;

   logic         we_b;
   logic [4:0]   waddr_b;
   logic [31:0]  wdata_b;
   logic [3:0]   wbe_b;
   logic [19:0]  raddr_b;
   logic [127:0] rdata_b;

   logic [31:0] ma [32];
   logic [31:0] mb [24];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
      .wbe(wbe_a), .raddr(raddr_a), .rdata(rdata_a)
   );

   regfile_mp #(.WIDTH(32), .DEPTH(24), .NRD(4), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
      .wbe(wbe_b), .raddr(raddr_b), .rdata(rdata_b)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = data[8*k +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_a(input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 32'h0;
      if (we_a && waddr_a == a) return merge(ma[a], wdata_a, wbe_a);
      return ma[a];
   endfunction

   function automatic logic [31:0] exp_b(input logic [4:0] a);
      if (!rst_n || a >= 5'd24) return 32'h0;
      return mb[a];
   endfunction

   // Advance one clock and apply the architectural effect of the edge to the model.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) ma[i] = 32'h0;
         for (int i = 0; i < 24; i++) mb[i] = 32'h0;
      end else begin
         if (we_a && waddr_a != 5'd0) ma[waddr_a] = merge(ma[waddr_a], wdata_a, wbe_a);
         if (we_b && waddr_b < 5'd24) mb[waddr_b] = merge(mb[waddr_b], wdata_b, wbe_b);
      end
      #1;
   endtask

   task automatic idle();
      we_a = 1'b0; we_b = 1'b0;
      wbe_a = 4'h0; wbe_b = 4'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      we_a = 1'b1; waddr_a = 5'd5; wdata_a = $urandom | 32'h1; wbe_a = 4'hF;
      we_b = 1'b1; waddr_b = 5'd5; wdata_b = $urandom | 32'h1; wbe_b = 4'hF;
      tick();
      for (int a = 0; a < 32; a++) begin
         raddr_a = {2{5'(a)}};
         raddr_b = {4{5'(a)}};
         #1;
         for (int p = 0; p < 2; p++) begin
            n_tests++;
            if (rdata_a[p*32 +: 32] !== 32'h0) begin
               n_fail++;
               $display("FAIL reset_rd_a addr=%0d port=%0d got=%h exp=0", a, p, rdata_a[p*32 +: 32]);
            end
         end
         for (int p = 0; p < 4; p++) begin
            n_tests++;
            if (rdata_b[p*32 +: 32] !== 32'h0) begin
               n_fail++;
               $display("FAIL reset_rd_b addr=%0d port=%0d got=%h exp=0", a, p, rdata_b[p*32 +: 32]);
            end
         end
      end
      rst_n = 1'b1;
      idle();
      tick();
      for (int a = 0; a < 32; a++) begin
         raddr_a = {2{5'(a)}};
         raddr_b = {4{5'(a)}};
         #1;
         n_tests++;
         if (rdata_a[31:0] !== 32'h0 || rdata_a[63:32] !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_a addr=%0d got=%h exp=0", a, rdata_a);
         end
         n_tests++;
         if (rdata_b !== 128'h0) begin
            n_fail++;
            $display("FAIL post_reset_b addr=%0d got=%h exp=0", a, rdata_b);
         end
      end
      rst_n = 1'b0;
      we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hCAFEF00D; wbe_a = 4'hF;
      we_b = 1'b1; waddr_b = 5'd5; wdata_b = 32'hCAFEF00D; wbe_b = 4'hF;
      tick();
      rst_n = 1'b1;
      idle();
      raddr_a = {5'd5, 5'd5};
      raddr_b = {4{5'd5}};
      #1;
      n_tests++;
      if (rdata_a[31:0] !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_wins_a got=%h exp=0", rdata_a[31:0]);
      end
      n_tests++;
      if (rdata_b[31:0] !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_wins_b got=%h exp=0", rdata_b[31:0]);
      end
      tick();
   endtask

   task automatic test_byte_write();
      we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hDEADBEEF; wbe_a = 4'b1111;
      tick();
      idle();
      raddr_a = {5'd0, 5'd7};
      #1;
      n_tests++;
      if (rdata_a[31:0] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL full_write got=%h exp=deadbeef", rdata_a[31:0]);
      end
      we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h000000AA; wbe_a = 4'b0001;
      tick();
      idle();
      #1;
      n_tests++;
      if (rdata_a[31:0] !== 32'hDEADBEAA) begin
         n_fail++;
         $display("FAIL byte_write got=%h exp=deadbeaa", rdata_a[31:0]);
      end
      we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h12345678; wbe_a = 4'b0000;
      tick();
      idle();
      #1;
      n_tests++;
      if (rdata_a[31:0] !== 32'hDEADBEAA) begin
         n_fail++;
         $display("FAIL no_byte_write got=%h exp=deadbeaa", rdata_a[31:0]);
      end
   endtask

   task automatic test_zero_reg();
      we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF; wbe_a = 4'hF;
      we_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hFFFFFFFF; wbe_b = 4'hF;
      raddr_a = {5'd0, 5'd0};
      #1;
      n_tests++;
      if (rdata_a[31:0] !== 32'h0) begin
         n_fail++;
         $display("FAIL zero_no_bypass got=%h exp=0", rdata_a[31:0]);
      end
      tick();
      idle();
      raddr_b = {4{5'd0}};
      #1;
      n_tests++;
      if (rdata_a[31:0] !== 32'h0) begin
         n_fail++;
         $display("FAIL zero_reg_a got=%h exp=0", rdata_a[31:0]);
      end
      n_tests++;
      if (rdata_b[31:0] !== 32'hFFFFFFFF) begin
         n_fail++;
         $display("FAIL no_zero_reg_b got=%h exp=ffffffff", rdata_b[31:0]);
      end
   endtask

   task automatic test_bypass();
      we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h11223344; wbe_a = 4'hF;
      we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'h11223344; wbe_b = 4'hF;
      tick();
      we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hAABBCCDD; wbe_a = 4'b1100;
      we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'hAABBCCDD; wbe_b = 4'b1100;
      raddr_a = {5'd3, 5'd0};
      raddr_b = {5'd0, 5'd0, 5'd3, 5'd0};
      #2;
      n_tests++;
      if (rdata_a[63:32] !== 32'hAABB3344) begin
         n_fail++;
         $display("FAIL bypass_a got=%h exp=aabb3344", rdata_a[63:32]);
      end
      n_tests++;
      if (rdata_b[63:32] !== 32'h11223344) begin
         n_fail++;
         $display("FAIL no_bypass_pre_b got=%h exp=11223344", rdata_b[63:32]);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (rdata_b[63:32] !== 32'hAABB3344) begin
         n_fail++;
         $display("FAIL no_bypass_post_b got=%h exp=aabb3344", rdata_b[63:32]);
      end
      n_tests++;
      if (rdata_a[63:32] !== 32'hAABB3344) begin
         n_fail++;
         $display("FAIL bypass_post_a got=%h exp=aabb3344", rdata_a[63:32]);
      end
   endtask

   task automatic test_depth();
      logic [31:0] snap [24];
      for (int i = 0; i < 24; i++) snap[i] = mb[i];
      we_b = 1'b1; waddr_b = 5'd30; wdata_b = 32'hA5A5A5A5; wbe_b = 4'hF;
      tick();
      idle();
      for (int a = 0; a < 24; a += 4) begin
         raddr_b = {5'(a+3), 5'(a+2), 5'(a+1), 5'(a)};
         #1;
         for (int p = 0; p < 4; p++) begin
            n_tests++;
            if (rdata_b[p*32 +: 32] !== snap[a+p]) begin
               n_fail++;
               $display("FAIL oor_write addr=%0d got=%h exp=%h", a+p, rdata_b[p*32 +: 32], snap[a+p]);
            end
         end
      end
      raddr_b = {4{5'd30}};
      #1;
      n_tests++;
      if (rdata_b !== 128'h0) begin
         n_fail++;
         $display("FAIL oor_read got=%h exp=0", rdata_b);
      end
      we_b = 1'b1; waddr_b = 5'd23; wdata_b = 32'h5; wbe_b = 4'hF;
      tick();
      idle();
      raddr_b = {4{5'd23}};
      #1;
      n_tests++;
      if (rdata_b[31:0] !== 32'h5) begin
         n_fail++;
         $display("FAIL last_entry got=%h exp=5", rdata_b[31:0]);
      end
   endtask

   task automatic test_nrd4();
      for (int i = 1; i <= 4; i++) begin
         we_b = 1'b1; waddr_b = 5'(i); wdata_b = 32'(i); wbe_b = 4'hF;
         tick();
      end
      idle();
      raddr_b = {5'd4, 5'd3, 5'd2, 5'd1};
      #1;
      n_tests++;
      if (rdata_b !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
         n_fail++;
         $display("FAIL four_ports got=%h exp=4,3,2,1", rdata_b);
      end
      raddr_b = {4{5'd2}};
      #1;
      n_tests++;
      if (rdata_b !== {4{32'd2}}) begin
         n_fail++;
         $display("FAIL same_addr got=%h exp=2 on all", rdata_b);
      end
   endtask

   task automatic test_random();
      logic [31:0] e;
      for (int c = 0; c < 400; c++) begin
         rst_n   = ($urandom_range(0, 49) != 0);
         we_a    = $urandom_range(0, 2) != 0;
         waddr_a = 5'($urandom);
         wdata_a = $urandom;
         wbe_a   = 4'($urandom);
         raddr_a = ($urandom_range(0, 2) == 0) ? {waddr_a, 5'($urandom)} : 10'($urandom);
         we_b    = $urandom_range(0, 2) != 0;
         waddr_b = 5'($urandom);
         wdata_b = $urandom;
         wbe_b   = 4'($urandom);
         raddr_b = ($urandom_range(0, 2) == 0) ? {15'($urandom), waddr_b} : 20'($urandom);
         #2;
         for (int p = 0; p < 2; p++) begin
            e = exp_a(raddr_a[p*5 +: 5]);
            n_tests++;
            if (rdata_a[p*32 +: 32] !== e) begin
               n_fail++;
               $display("FAIL rand_a cyc=%0d port=%0d got=%h exp=%h", c, p, rdata_a[p*32 +: 32], e);
            end
         end
         for (int p = 0; p < 4; p++) begin
            e = exp_b(raddr_b[p*5 +: 5]);
            n_tests++;
            if (rdata_b[p*32 +: 32] !== e) begin
               n_fail++;
               $display("FAIL rand_b cyc=%0d port=%0d got=%h exp=%h", c, p, rdata_b[p*32 +: 32], e);
            end
         end
         tick();
      end
      rst_n = 1'b1;
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      waddr_a = '0; wdata_a = '0; raddr_a = '0;
      waddr_b = '0; wdata_b = '0; raddr_b = '0;
      for (int i = 0; i < 32; i++) ma[i] = 32'h0;
      for (int i = 0; i < 24; i++) mb[i] = 32'h0;
      tick();
      test_reset();
      test_byte_write();
      test_zero_reg();
      test_bypass();
      test_depth();
      test_nrd4();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: DEPTH words of WIDTH bits, NRD independent combinational read ports, and one synchronous write port with byte enables. Optional hardwired-zero entry 0 and optional write-to-read bypass. Intended as the processor datapath's architectural register file, replacing the fixed 32-bit single-register array.

## Interface
Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; must be ≥ 2 and need not be a power of 2.
- NRD, 2, number of read ports; range 1 to 4.
- ZERO_REG, 1, if 1, entry 0 reads as 0 and ignores writes.
- BYPASS, 1, if 1, a read of the address being written this cycle returns the merged new data.
- AW, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- wbe  in  WIDTH/8  byte enables; bit k enables wdata[8k+7:8k].
- raddr  in  NRD*AW  packed read addresses; port p is raddr[p*AW +: AW].
- rdata  out  NRD*WIDTH  packed read data; port p is rdata[p*WIDTH +: WIDTH].

## Operation
- Reset: on a rising clk edge with rst_n=0, all DEPTH entries clear to 0 and any write in that cycle is discarded. While rst_n=0, every rdata port is forced to 0.
- Write: on a rising clk edge with rst_n=1, we=1, waddr<DEPTH, and not (ZERO_REG=1 and waddr=0), each byte k of entry waddr with wbe[k]=1 takes wdata byte k. Bytes with wbe[k]=0 keep their value. A write with wbe=0 changes nothing.
- Out-of-range writes (waddr ≥ DEPTH) are ignored.
- Read: each port is combinational, rdata_p = entry[raddr_p].
  - raddr_p ≥ DEPTH → 0.
  - ZERO_REG=1 and raddr_p=0 → 0, regardless of bypass.
- Bypass (BYPASS=1): when rst_n=1, we=1, and raddr_p equals a valid waddr, rdata_p returns the stored entry with the enabled bytes replaced by wdata. This is the value the entry will hold after the edge.
- Without bypass (BYPASS=0): rdata_p returns the pre-edge value.
- Several ports may read the same address; each returns the identical value.

## Timing
- Write latency: 1 cycle; the new value is visible on a non-bypassed read in the cycle after the edge.
- Read latency: 0 cycles, combinational from raddr, and from we/waddr/wdata/wbe when BYPASS=1.
- Reset latency: entries are 0 after the first rst_n=0 edge. rdata is 0 during reset and stays 0 in the first cycle after rst_n rises, unless a bypassed write is in flight.
- Reset asserted mid-write: reset wins and the entry becomes 0.
- No internal state machine; the only state is the storage array.

## Structure
- Package regfile_pkg holds:
  - default constants RF_WIDTH=32, RF_DEPTH=32, RF_NRD=2;
  - function bytes_of(width) returning width/8;
  - an elaboration check that fails if WIDTH%8≠0, DEPTH<2, or NRD is outside 1..4.
- Sub-module regfile_word: one WIDTH-bit register with synchronous active-low clear, a write strobe, and byte enables. It is instantiated DEPTH times via generate; when ZERO_REG=1, word 0 is omitted and tied to 0.
- Top level holds the write-address decode, the per-port read mux, and the bypass merge logic.

## Test plan
- Reset, then read all addresses on both ports → every rdata = 0. Reassert rst_n=0 while we=1, waddr=5 → entry 5 still 0.
- Write 0xDEADBEEF to waddr=7 with wbe=4'b1111; next cycle raddr0=7 → 0xDEADBEEF. Then write 0x000000AA with wbe=4'b0001 → 0xDEADBEAA.
- ZERO_REG=1: write 0xFFFFFFFF to waddr=0, then read port 0 at addr 0 → 0. With ZERO_REG=0, same sequence → 0xFFFFFFFF.
- BYPASS=1, entry 3 = 0x11223344: in the same cycle we=1, waddr=3, wdata=0xAABBCCDD, wbe=4'b1100, raddr1=3 → rdata1 = 0xAABB3344 before the edge. With BYPASS=0 → 0x11223344 before the edge and 0xAABB3344 after.
- DEPTH=24: write to waddr=30 → no entry changes. Read raddr=30 → 0. Write waddr=23 with 0x5 → reads back 0x5.
- NRD=4: load entries 1–4 with 1,2,3,4; read addresses {4,3,2,1} on the four ports simultaneously → {4,3,2,1}. All four ports at addr 2 → 2 on each.
